// File: rtl/softmax_exp_accum.sv
// softmax_exp_accum
//   Accumulates the softmax denominator sum(exp(x_i)) for one vector at a time.
//   It consumes the exponent stream after the alignment delay line. The final sum
//   is offered to the normalisation stage over a valid/ready handshake. A new
//   vector is accepted only after the previous sum has been taken.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   start_i      1-cycle pulse that begins a vector; samples vec_len_i
//   vec_len_i    element count of the vector (0 means the start is ignored)
//   in_valid_i   in_data_i carries one element this cycle
//   in_data_i    unsigned exp value
//   busy_o       high from the cycle after an accepted start until the sum handshake
//   sum_valid_o  sum_data_o / sum_ovf_o valid; held until sum_ready_i
//   sum_ready_i  downstream takes the sum when sum_valid_o is high
//   sum_data_o   final accumulated (saturating) sum
//   sum_ovf_o    the accumulator saturated at least once in this vector
//
// FSM states
//   state   | meaning
//   S_IDLE  | waiting for a start with a non-zero length
//   S_ACCUM | adding elements until len_q of them have arrived
//   S_HOLD  | sum presented, waiting for sum_ready_i

module softmax_exp_accum #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8,
  parameter int SUM_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  vec_len_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              busy_o,
  output logic              sum_valid_o,
  input  logic              sum_ready_i,
  output logic [SUM_W-1:0]  sum_data_o,
  output logic              sum_ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [SUM_W-1:0]   sum_data_q, sum_data_d;
  logic               sum_ovf_q, sum_ovf_d;

  // One extra bit of headroom exposes the carry that signals saturation.
  logic [SUM_W:0]     in_ext;
  logic [SUM_W:0]     sum_wide;
  logic               sat;
  logic [SUM_W-1:0]   acc_next;
  logic               last_elem;

  assign in_ext    = {{(SUM_W + 1 - DATA_W){1'b0}}, in_data_i};
  assign sum_wide  = {1'b0, acc_q} + in_ext;
  assign sat       = sum_wide[SUM_W];
  assign acc_next  = sat ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
  assign last_elem = in_valid_i && (cnt_q == (len_q - LEN_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      sum_data_q <= '0;
      sum_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      sum_data_q <= sum_data_d;
      sum_ovf_q  <= sum_ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    sum_data_d = sum_data_q;
    sum_ovf_d  = sum_ovf_q;
    busy_o     = 1'b0;
    sum_valid_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && (vec_len_i != '0)) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          len_d   = vec_len_i;
        end
      end

      S_ACCUM: begin
        busy_o = 1'b1;
        if (in_valid_i) begin
          acc_d = acc_next;
          cnt_d = cnt_q + LEN_W'(1);
          ovf_d = ovf_q | sat;
          // The output registers are loaded only here. They then stay
          // stable through HOLD and the following vector until its end.
          if (last_elem) begin
            state_d    = S_HOLD;
            sum_data_d = acc_next;
            sum_ovf_d  = ovf_q | sat;
          end
        end
      end

      S_HOLD: begin
        busy_o      = 1'b1;
        sum_valid_o = 1'b1;
        if (sum_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sum_data_o = sum_data_q;
  assign sum_ovf_o  = sum_ovf_q;

endmodule

// File: tb/tb_softmax_exp_accum.sv
module tb_softmax_exp_accum;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;
  localparam int SUM_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  vec_len = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              busy;
  logic              sum_valid;
  logic              sum_ready = 1'b0;
  logic [SUM_W-1:0]  sum_data;
  logic              sum_ovf;

  softmax_exp_accum #(
    .DATA_W(DATA_W),
    .LEN_W (LEN_W),
    .SUM_W (SUM_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .vec_len_i  (vec_len),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .busy_o     (busy),
    .sum_valid_o(sum_valid),
    .sum_ready_i(sum_ready),
    .sum_data_o (sum_data),
    .sum_ovf_o  (sum_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [SUM_W-1:0] data;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
    end
  endtask

  task automatic push_exp(input logic [SUM_W-1:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    exp_q.push_back(e);
  endtask

  // Monitor: every completed handshake is compared to the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && sum_valid && sum_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_sum: got 0x%0h, required no output", sum_data);
      end else begin
        e = exp_q.pop_front();
        chk("sum_data", {16'h0, sum_data}, {16'h0, e.data});
        chk("sum_ovf", {31'h0, sum_ovf}, {31'h0, e.ovf});
      end
    end
  end

  // Inputs change 1 time unit after a rising edge and are consumed by the next one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_vec(input int len);
    start   = 1'b1;
    vec_len = LEN_W'(len);
    step();
    start   = 1'b0;
  endtask

  task automatic elem(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic take_sum(input string tag);
    chk({tag, "_valid"}, {31'h0, sum_valid}, 32'd1);
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    chk({tag, "_busy_after"}, {31'h0, busy}, 32'd0);
    chk({tag, "_valid_after"}, {31'h0, sum_valid}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset state
    #12;
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_valid", {31'h0, sum_valid}, 32'd0);
    chk("rst_data", {16'h0, sum_data}, 32'd0);
    chk("rst_ovf", {31'h0, sum_ovf}, 32'd0);
    rst = 1'b1;
    step();

    // T1: back-to-back 1,2,3,4
    push_exp(16'd10, 1'b0);
    begin_vec(4);
    chk("t1_busy", {31'h0, busy}, 32'd1);
    elem(16'd1);
    elem(16'd2);
    elem(16'd3);
    chk("t1_early_valid", {31'h0, sum_valid}, 32'd0);
    elem(16'd4);
    take_sum("t1");

    // T2: two idle cycles between elements
    push_exp(16'h0600, 1'b0);
    begin_vec(3);
    elem(16'h0100);
    step(); step();
    elem(16'h0200);
    step(); step();
    chk("t2_gap_valid", {31'h0, sum_valid}, 32'd0);
    elem(16'h0300);
    take_sum("t2");

    // T3: saturation
    push_exp(16'hFFFF, 1'b1);
    begin_vec(2);
    elem(16'hFFFF);
    elem(16'h0002);
    take_sum("t3");

    // T4: sum held while ready is low; start and in_valid pulses ignored
    push_exp(16'h1245, 1'b0);
    begin_vec(2);
    elem(16'h1234);
    elem(16'h0011);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", {31'h0, sum_valid}, 32'd1);
      chk("t4_hold_data", {16'h0, sum_data}, 32'h1245);
      start    = 1'b1;
      vec_len  = 8'd3;
      in_valid = 1'b1;
      in_data  = 16'h0055;
      step();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("t4_hold_data_end", {16'h0, sum_data}, 32'h1245);
    take_sum("t4");

    // T5: zero-length start ignored; start during ACCUM ignored
    begin_vec(0);
    chk("t5_zero_len_busy", {31'h0, busy}, 32'd0);
    elem(16'h0077);
    push_exp(16'd11, 1'b0);
    begin_vec(2);
    elem(16'd5);
    start   = 1'b1;
    vec_len = 8'd5;
    step();
    start   = 1'b0;
    chk("t5_restart_busy", {31'h0, busy}, 32'd1);
    chk("t5_restart_valid", {31'h0, sum_valid}, 32'd0);
    elem(16'd6);
    take_sum("t5");

    // T6: asynchronous reset mid-vector discards the partial sum
    begin_vec(4);
    elem(16'd1);
    elem(16'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_busy", {31'h0, busy}, 32'd0);
    chk("t6_rst_valid", {31'h0, sum_valid}, 32'd0);
    chk("t6_rst_data", {16'h0, sum_data}, 32'd0);
    chk("t6_rst_ovf", {31'h0, sum_ovf}, 32'd0);
    step();
    rst = 1'b1;
    step();
    push_exp(16'd7, 1'b0);
    begin_vec(1);
    elem(16'd7);
    take_sum("t6");

    step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
